// File: rtl/flight_frame_pkg.sv
// Shared constants, FSM state type and frame layout helper for the flight frame scheduler.
package flight_frame_pkg;

  localparam int unsigned FRAME_WORDS = 99;
  localparam int unsigned HDR_WORDS   = 3;
  localparam int unsigned N_ARINC     = 6;
  localparam logic [15:0] FRAME_SYNC  = 16'hA55A;

  typedef enum logic [1:0] {StIdle, StHdr, StRd, StDone} state_e;

  // Frame word holding ARINC channel c, RAM address w (w counts from 1).
  function automatic logic [6:0] arinc_word_idx(input logic [2:0] c, input logic [4:0] w,
                                                input int unsigned words = 16);
    int unsigned idx;
    idx = HDR_WORDS + 32'(c) * words + 32'(w) - 1;
    return idx[6:0];
  endfunction

endpackage

// File: rtl/flight_frame_ram.sv
// Ping-pong frame memory: 2 banks x 128 x 32, one write port, one registered read port.
module flight_frame_ram (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic        wr_bank_i,
  input  logic [6:0]  wr_addr_i,
  input  logic [31:0] wr_data_i,
  input  logic        rd_bank_i,
  input  logic [6:0]  rd_addr_i,
  output logic [31:0] rd_data_o
);

  logic [31:0] mem_q [256];

  // No reset so the array maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[{wr_bank_i, wr_addr_i}] <= wr_data_i;
    end
    rd_data_o <= mem_q[{rd_bank_i, rd_addr_i}];
  end

endmodule

// File: rtl/flight_frame_sched.sv
// Per-millisecond flight frame builder: snapshots tacho/impulse, reads six ARINC RAMs,
// assembles a 99-word frame into the write bank and publishes it to the transmitter.
module flight_frame_sched
  import flight_frame_pkg::*;
#(
  parameter int unsigned ARINC_WORDS    = 16,
  parameter int unsigned MSEC_PER_FRAME = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        msec,
  input  logic [15:0] freq1,
  input  logic [15:0] freq2,
  input  logic [15:0] imp,
  output logic [4:0]  rd_arinc,
  input  logic [95:0] arinc_q,
  input  logic [6:0]  rd_FLIGHT,
  output logic [31:0] FLIGHT_out,
  output logic        frame_rdy,
  output logic [15:0] frame_cnt,
  output logic        busy,
  output logic [7:0]  overrun
);

  localparam logic [7:0] DivLast  = 8'(MSEC_PER_FRAME - 1);
  localparam logic [4:0] LastAddr = 5'(ARINC_WORDS);
  localparam logic [2:0] LastCh   = 3'(N_ARINC - 1);

  state_e      state_q;
  logic [7:0]  div_q, overrun_q;
  logic        pending_q, bank_q, valid_q, frame_rdy_q, busy_q, zero_q;
  logic [15:0] freq1_s_q, freq2_s_q, imp_s_q, frame_cnt_q;
  logic [1:0]  hdr_cnt_q;
  logic [4:0]  rd_arinc_q, wr_w_q;
  logic [2:0]  ch_q, wr_ch_q;
  logic        wr_vld_q;
  logic        trigger;

  logic        ram_we;
  logic [6:0]  ram_waddr;
  logic [31:0] ram_wdata, ram_rdata;

  assign trigger = msec && (div_q == DivLast);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      div_q       <= '0;
      overrun_q   <= '0;
      pending_q   <= 1'b0;
      bank_q      <= 1'b0;
      valid_q     <= 1'b0;
      frame_rdy_q <= 1'b0;
      busy_q      <= 1'b0;
      freq1_s_q   <= '0;
      freq2_s_q   <= '0;
      imp_s_q     <= '0;
      frame_cnt_q <= '0;
      hdr_cnt_q   <= '0;
      rd_arinc_q  <= '0;
      ch_q        <= '0;
      wr_vld_q    <= 1'b0;
      wr_w_q      <= '0;
      wr_ch_q     <= '0;
    end else begin
      frame_rdy_q <= 1'b0;
      wr_vld_q    <= 1'b0;
      if (msec) begin
        div_q <= trigger ? '0 : div_q + 8'd1;
      end
      unique case (state_q)
        StIdle: begin
          freq1_s_q <= freq1;
          freq2_s_q <= freq2;
          imp_s_q   <= imp;
          pending_q <= 1'b0;
          if (trigger || pending_q) begin
            state_q   <= StHdr;
            busy_q    <= 1'b1;
            hdr_cnt_q <= '0;
          end
        end
        StHdr: begin
          if (hdr_cnt_q == 2'd2) begin
            state_q    <= StRd;
            rd_arinc_q <= 5'd1;
            ch_q       <= '0;
          end else begin
            hdr_cnt_q <= hdr_cnt_q + 2'd1;
          end
        end
        StRd: begin
          // Address and channel travel together to line up with the 1-cycle RAM read.
          wr_vld_q <= (rd_arinc_q != '0);
          wr_w_q   <= rd_arinc_q;
          wr_ch_q  <= ch_q;
          if (rd_arinc_q == '0) begin
            state_q     <= StDone;
            frame_rdy_q <= 1'b1;
            frame_cnt_q <= frame_cnt_q + 16'd1;
          end else if (rd_arinc_q == LastAddr) begin
            rd_arinc_q <= (ch_q == LastCh) ? 5'd0 : 5'd1;
            ch_q       <= ch_q + 3'd1;
          end else begin
            rd_arinc_q <= rd_arinc_q + 5'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          bank_q  <= ~bank_q;
          valid_q <= 1'b1;
        end
      endcase
      if (state_q != StIdle && trigger) begin
        if (pending_q) begin
          if (overrun_q != 8'hFF) overrun_q <= overrun_q + 8'd1;
        end else begin
          pending_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    if (state_q == StHdr) begin
      ram_we    = 1'b1;
      ram_waddr = {5'b0, hdr_cnt_q};
      case (hdr_cnt_q)
        2'd0:    ram_wdata = {FRAME_SYNC, frame_cnt_q + 16'd1};
        2'd1:    ram_wdata = {freq1_s_q, freq2_s_q};
        default: ram_wdata = {imp_s_q, 16'h0000};
      endcase
    end else if (wr_vld_q) begin
      ram_we    = 1'b1;
      ram_waddr = arinc_word_idx(wr_ch_q, wr_w_q, ARINC_WORDS);
      ram_wdata = {{5'b0, wr_ch_q} + 8'd1, 3'b000, wr_w_q, arinc_q[{wr_ch_q, 4'b0000} +: 16]};
    end
  end

  // Zero select is registered alongside the RAM read so it matches the data it gates.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      zero_q <= 1'b1;
    end else begin
      zero_q <= !valid_q || (rd_FLIGHT >= 7'(FRAME_WORDS));
    end
  end

  flight_frame_ram u_ram (
    .clk_i     (clock),
    .we_i      (ram_we),
    .wr_bank_i (~bank_q),
    .wr_addr_i (ram_waddr),
    .wr_data_i (ram_wdata),
    .rd_bank_i (bank_q),
    .rd_addr_i (rd_FLIGHT),
    .rd_data_o (ram_rdata)
  );

  assign FLIGHT_out = zero_q ? 32'h0 : ram_rdata;
  assign rd_arinc   = rd_arinc_q;
  assign frame_rdy  = frame_rdy_q;
  assign frame_cnt  = frame_cnt_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/flight_frame_sched.md
# flight_frame_sched

Per-millisecond scheduler that builds the flight data frame consumed by the audio/data transmitter. On each `msec` strobe it snapshots the tachometer and impulse counters, sequences reads of the six ARINC-429 receive RAMs over one shared read-address bus, and assembles a 99-word frame into a ping-pong buffer. It then hands the completed bank to the transmitter through `frame_rdy`, `frame_cnt` and the `rd_FLIGHT`/`FLIGHT_out` read port. It sits between RZ_LINE_TOP, TAHO_IMPULS_TOP and Get_All_and_Trans_TOP.

## Interface
Parameters:
- `ARINC_WORDS`, 16: words read per ARINC channel, at RAM addresses 1..ARINC_WORDS.
- `MSEC_PER_FRAME`, 1: number of `msec` strobes per frame build, 1..255.

Ports:
- `clock`, in, 1: single system clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `msec`, in, 1: one-cycle millisecond strobe.
- `freq1`, `freq2`, `imp`, in, 16 each: tacho and impulse results.
- `rd_arinc`, out, 5: shared read address, fanned out to all six `rd_arincN`.
- `arinc_q`, in, 96: packed `{arinc_6_outp … arinc_1_outp}`. RAM read latency is 1 cycle.
- `rd_FLIGHT`, in, 7: transmitter read address.
- `FLIGHT_out`, out, 32: frame word, registered with 1-cycle latency.
- `frame_rdy`, out, 1: one-cycle pulse when a new bank is published.
- `frame_cnt`, out, 16: count of frames published.
- `busy`, out, 1: a frame build is in progress.
- `overrun`, out, 8: saturating count of dropped triggers.

## Operation
- **Trigger.** A divider counts `msec` strobes. Every `MSEC_PER_FRAME`-th strobe is a trigger.
- **State machine:** IDLE → HDR → RD → DONE → IDLE.
- **IDLE.**
  - If there is a trigger or `pending` is set, go to HDR.
  - Clear `pending` and latch `freq1`/`freq2`/`imp` into snapshot registers.
- **HDR.** Write three words into the write bank, one per cycle:
  - word 0 = `{16'hA55A, frame_cnt+1}`
  - word 1 = `{freq1_s, freq2_s}`
  - word 2 = `{imp_s, 16'h0000}`
- **RD.**
  - Issue `rd_arinc` = 1..ARINC_WORDS for channel 0, then channel 1, up to channel 5. One address per cycle, 96 issues.
  - Write pipeline: one cycle after each issue, write word `3 + c*ARINC_WORDS + (w-1)` = `{8'(c+1), 3'b0, 5'(w), arinc_q[c*16 +: 16]}`.
  - The channel select is pipelined together with the address.
- **DONE** (one cycle):
  - Toggle the bank so the write bank becomes the read bank.
  - Pulse `frame_rdy`.
  - Increment `frame_cnt`, wrapping 16'hFFFF → 0.
  - Set the `valid` flag.
- **Read side.**
  - `FLIGHT_out` = read_bank[`rd_FLIGHT`].
  - Returns 32'h0 when `valid`=0 or when `rd_FLIGHT` ≥ 99.
  - The read bank never changes except in DONE.
- **Trigger while busy** (HDR/RD/DONE): set `pending`. If `pending` is already set, the trigger is dropped and `overrun` increments, saturating at 255.
- **Simultaneous events.** A trigger in the same cycle as the DONE→IDLE transition sets `pending`. It is never lost.
- **Reset.**
  - Async assertion forces IDLE at any point, including mid-frame.
  - Reset values: `rd_arinc`=0, `frame_rdy`=0, `frame_cnt`=0, `busy`=0, `overrun`=0, `FLIGHT_out`=0, bank=0, `valid`=0, `pending`=0, divider=0.
  - A partially written bank is discarded because `valid`=0.
- `rd_arinc` holds 0 whenever the block is not in RD.

## Timing
Trigger `msec` sampled at cycle T:
- T+1..T+3: HDR writes.
- T+4..T+99: RD address issues.
- T+5..T+100: ARINC word writes.
- T+101: DONE. `frame_rdy`=1 and `frame_cnt` is updated at T+101.
- T+102: IDLE, `busy`=0. `busy`=1 from T+1 through T+101.
- Frame build is 101 cycles, so `clock` must be at least 102 cycles per frame period for overrun-free operation.
- A `pending` trigger restarts at T+103, HDR at T+103.
- `FLIGHT_out` is valid one cycle after `rd_FLIGHT`. A read at T+101 still returns the old bank; from T+102 it returns the new bank.

## Structure
- **Package `flight_frame_pkg`:**
  - Constants: `FRAME_WORDS`=99, `HDR_WORDS`=3, `N_ARINC`=6, `FRAME_SYNC`=16'hA55A.
  - State enum.
  - Word-index function `arinc_word_idx(c, w)`.
- **Sub-module `flight_frame_ram`:**
  - 2×128×32 ping-pong memory with one write port (bank, addr, data, we) and one registered read port (bank, addr).
  - Infers M9K.
- **Top:** FSM, divider, snapshot registers, pipeline registers and output zero-mux.

## Test plan
1. **Basic frame.** Reset release; `freq1`=16'h1234, `freq2`=16'h00FF, `imp`=16'h0007; ARINC model returns `{ch, addr}` data; one `msec` →
   - `frame_rdy` at T+101, `frame_cnt`=1.
   - Words 0..2 = A55A0001, 123400FF, 00070000.
   - Word 3 = 01_01_0101; word 98 = 06_10_0610.
2. **Trigger while busy.**
   - `msec` at T and T+50 → second frame starts at T+103, `frame_cnt`=2, `overrun`=0.
   - A third `msec` at T+60 → `overrun`=1.
3. **Bank stability.** Continuous reads of word 1 during the second build → old value until T+102, new value after. Reads at `rd_FLIGHT`=99 and 127 → 0.
4. **Reset mid-frame.** Assert `reset` at T+40 →
   - All outputs at reset values immediately.
   - `FLIGHT_out`=0 until the next full frame.
   - The next frame carries `frame_cnt`=1.
5. **Divider and wrap.**
   - `MSEC_PER_FRAME`=4 → `frame_rdy` only on every 4th `msec`.
   - `frame_cnt` preloaded to FFFF by forcing → wraps to 0000; header word 0 = A55A0000.
6. **Simultaneous events.** Trigger coincident with the DONE cycle → `pending` set, next HDR starts 2 cycles later, no overrun.
